coffee_brewer_1557: RTL and testbench
=====================================

COFFEE_BREWER_1557 -- requirements
Module: coffee_brewer_1557

Interface
REQ-001 The block SHALL provide parameter CUP_CYCLES, default 4, which is the number of cycles cup_drop is high.
REQ-002 The block SHALL provide parameter HEAT_CYCLES, default 8, which is the number of cycles heater_on is high.
REQ-003 The block SHALL provide parameter POUR_CYCLES, default 6, which is the number of cycles valve_open is high.
REQ-004 The block SHALL provide parameter PORTIONS, default 3, which is the number of coffees per refill (1..255).
REQ-005 The block SHALL provide parameter READY_TIMEOUT, default 1000, which is the number of cycles before a forced cup release (used only with the macro in REQ-027).
REQ-006 Port clk11m, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 Port prepare_coffee, input, 1 bit: brew request from the vending controller; its rising edge is the trigger.
REQ-009 Port cup_sensor, input, 1 bit: 1 = cup on tray; synchronous to clk11m.
REQ-010 Port refill, input, 1 bit: one-cycle service pulse that reloads portions and clears the cup fault.
REQ-011 Port coffee_ready, output, 1 bit: coffee poured, waiting for cup removal.
REQ-012 Port cup_out, output, 1 bit: one-cycle pulse when the cup is removed.
REQ-013 Port machine_empty, output, 1 bit: no portions left, or cup magazine fault.
REQ-014 Ports cup_drop, heater_on, valve_open, outputs, 1 bit each: actuator enables.

Function
REQ-015 The block SHALL be a Moore FSM with states IDLE, DROP, HEAT, POUR, READY; all outputs registered.
REQ-016 A register prepare_q SHALL hold the previous prepare_coffee; start = prepare_coffee & ~prepare_q & IDLE & ~machine_empty.
REQ-017 When start is sampled at edge k, the block SHALL go to DROP; cup_drop high in cycles k+1..k+CUP_CYCLES.
REQ-018 The transitions DROP->HEAT->POUR SHALL use one down-counter (8-bit minimum), reloaded on each state entry; heater_on and valve_open SHALL each be high exactly HEAT_CYCLES and POUR_CYCLES cycles.
REQ-019 If cup_sensor = 0 in the last DROP cycle, the block SHALL set cup_fault, return to IDLE, and leave portions unchanged.
REQ-020 On POUR exit, portions SHALL decrement by 1 (no wrap below 0), and the block SHALL enter READY; coffee_ready SHALL be high from cycle k+1+CUP_CYCLES+HEAT_CYCLES+POUR_CYCLES.
REQ-021 In READY, a cup_sensor 1->0 transition (registered cup_q) SHALL produce:
  - cup_out high for exactly one cycle, on the cycle after the fall is sampled;
  - coffee_ready low in that same cycle;
  - state IDLE.
REQ-022 machine_empty SHALL equal (portions == 0) | cup_fault, registered.
REQ-023 refill SHALL act only in IDLE: portions := PORTIONS and cup_fault := 0; in any other state it SHALL be ignored.
REQ-024 The block SHALL ignore these inputs:
  - prepare_coffee held high (no retrigger);
  - a rising edge outside IDLE;
  - a rising edge while machine_empty = 1.
REQ-025 If start and refill occur in the same cycle in IDLE, the block SHALL apply the refill and also accept the start, evaluated against the reloaded count.

Reset
REQ-026 While rst_n = 0, the block SHALL immediately set:
  - state IDLE and portions = PORTIONS;
  - cup_fault, prepare_q, cup_q and all counters = 0;
  - all outputs 0, including mid-brew.

Configuration
REQ-027 Macro READY_TIMEOUT_EN SHALL control the READY timeout:
  - Defined: READY counts cycles; after READY_TIMEOUT cycles without cup removal, the block SHALL emit the REQ-021 cup_out pulse, drop coffee_ready and go to IDLE.
  - Undefined: there is no timer, and READY waits indefinitely.

Verification
REQ-028 Reset, then a prepare_coffee pulse with cup_sensor rising during DROP -> cup_drop 4 cycles, heater_on 8, valve_open 6, coffee_ready at cycle 19; cup_sensor low -> one cup_out pulse.
REQ-029 Three full brews after reset -> machine_empty = 1 after the third POUR; a fourth prepare_coffee is ignored; refill -> machine_empty = 0 and a brew succeeds.
REQ-030 prepare_coffee with cup_sensor held 0 -> IDLE after 4 cycles of cup_drop, machine_empty = 1, portions still 3; refill clears it.
REQ-031 prepare_coffee held high for 40 cycles -> exactly one brew; a second pulse during HEAT -> ignored.
REQ-032 rst_n low during HEAT -> all outputs 0 at once; after release, a brew starts from IDLE with portions = 3.
REQ-033 With READY_TIMEOUT_EN and READY_TIMEOUT = 20, cup never removed -> cup_out pulse and coffee_ready low 20 cycles after READY entry.

Source files
------------

// File: rtl/coffee_brewer_1557.sv
// rtl/coffee_brewer_1557.sv - coffee sequencer: cup drop, heat, pour, wait for cup removal
// Optional READY_TIMEOUT_EN: forced cup release after READY_TIMEOUT cycles in READY.
module coffee_brewer_1557 #(
  parameter int CUP_CYCLES    = 4,
  parameter int HEAT_CYCLES   = 8,
  parameter int POUR_CYCLES   = 6,
  parameter int PORTIONS      = 3,
  parameter int READY_TIMEOUT = 1000
) (
  input  logic clk11m,
  input  logic rst_n,
  input  logic prepare_coffee,
  input  logic cup_sensor,
  input  logic refill,
  output logic coffee_ready,
  output logic cup_out,
  output logic machine_empty,
  output logic cup_drop,
  output logic heater_on,
  output logic valve_open
);

  localparam int MAX_A   = (CUP_CYCLES > HEAT_CYCLES) ? CUP_CYCLES : HEAT_CYCLES;
  localparam int MAX_B   = (POUR_CYCLES > READY_TIMEOUT) ? POUR_CYCLES : READY_TIMEOUT;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = ($clog2(MAX_LEN) > 8) ? $clog2(MAX_LEN) : 8;

  localparam logic [CNT_W-1:0] CUP_LOAD  = CNT_W'(CUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HEAT_LOAD = CNT_W'(HEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] POUR_LOAD = CNT_W'(POUR_CYCLES - 1);
`ifdef READY_TIMEOUT_EN
  localparam logic [CNT_W-1:0] READY_LOAD = CNT_W'(READY_TIMEOUT - 1);
`else
  localparam logic [CNT_W-1:0] READY_LOAD = '0;
`endif
  localparam logic [7:0] PORTIONS_INIT = 8'(PORTIONS);

  typedef enum logic [2:0] {IDLE, DROP, HEAT, POUR, READY} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [7:0]       portions, portions_d;
  logic             cup_fault, cup_fault_d;
  logic             prepare_q, cup_q;
  logic             cup_out_d;
  logic             rise, refill_ok, start, cup_fall;

  always_ff @(posedge clk11m or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      portions      <= PORTIONS_INIT;
      cup_fault     <= 1'b0;
      prepare_q     <= 1'b0;
      cup_q         <= 1'b0;
      cup_drop      <= 1'b0;
      heater_on     <= 1'b0;
      valve_open    <= 1'b0;
      coffee_ready  <= 1'b0;
      cup_out       <= 1'b0;
      machine_empty <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      portions      <= portions_d;
      cup_fault     <= cup_fault_d;
      prepare_q     <= prepare_coffee;
      cup_q         <= cup_sensor;
      // Outputs are decoded from the next state so they line up with it.
      cup_drop      <= (state_d == DROP);
      heater_on     <= (state_d == HEAT);
      valve_open    <= (state_d == POUR);
      coffee_ready  <= (state_d == READY);
      cup_out       <= cup_out_d;
      machine_empty <= (portions_d == 8'd0) | cup_fault_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    portions_d  = portions;
    cup_fault_d = cup_fault;
    cup_out_d   = 1'b0;

    rise      = prepare_coffee & ~prepare_q;
    refill_ok = refill & (state == IDLE);
    // A same-cycle refill makes the machine non-empty before start is judged.
    start     = rise & (state == IDLE) & (refill_ok | ~machine_empty);
    cup_fall  = cup_q & ~cup_sensor;

    if (cnt != '0) begin
      cnt_d = cnt - 1'b1;
    end

    case (state)
      IDLE: begin
        if (refill_ok) begin
          portions_d  = PORTIONS_INIT;
          cup_fault_d = 1'b0;
        end
        if (start) begin
          state_d = DROP;
          cnt_d   = CUP_LOAD;
        end
      end
      DROP: begin
        if (cnt == '0) begin
          if (!cup_sensor) begin
            cup_fault_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = HEAT;
            cnt_d   = HEAT_LOAD;
          end
        end
      end
      HEAT: begin
        if (cnt == '0) begin
          state_d = POUR;
          cnt_d   = POUR_LOAD;
        end
      end
      POUR: begin
        if (cnt == '0) begin
          state_d = READY;
          cnt_d   = READY_LOAD;
          if (portions != 8'd0) begin
            portions_d = portions - 8'd1;
          end
        end
      end
      READY: begin
`ifdef READY_TIMEOUT_EN
        if (cup_fall || (cnt == '0)) begin
`else
        if (cup_fall) begin
`endif
          cup_out_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_coffee_brewer_1557.sv
// tb/tb_coffee_brewer_1557.sv - randomized self-checking bench for coffee_brewer_1557
// Honors READY_TIMEOUT_EN when defined (timeout set to 20 cycles).
module tb_coffee_brewer_1557;

  localparam int C    = 4;
  localparam int H    = 8;
  localparam int P    = 6;
  localparam int PORT = 3;
  localparam int TO   = 20;
`ifdef READY_TIMEOUT_EN
  localparam bit USE_TO = 1'b1;
`else
  localparam bit USE_TO = 1'b0;
`endif

  logic clk11m = 1'b0;
  logic rst_n;
  logic prepare_coffee, cup_sensor, refill;
  logic coffee_ready, cup_out, machine_empty, cup_drop, heater_on, valve_open;

  int tests_run    = 0;
  int tests_failed = 0;

  coffee_brewer_1557 #(
    .CUP_CYCLES(C), .HEAT_CYCLES(H), .POUR_CYCLES(P),
    .PORTIONS(PORT), .READY_TIMEOUT(TO)
  ) dut (
    .clk11m(clk11m), .rst_n(rst_n), .prepare_coffee(prepare_coffee),
    .cup_sensor(cup_sensor), .refill(refill), .coffee_ready(coffee_ready),
    .cup_out(cup_out), .machine_empty(machine_empty), .cup_drop(cup_drop),
    .heater_on(heater_on), .valve_open(valve_open)
  );

  always #5 clk11m = ~clk11m;

  // Timeline model: a brew is tracked by edges elapsed since the accepted start.
  bit m_brew, m_ready, m_fault, m_prev_prep, m_prev_cup;
  int m_e, m_age, m_portions;
  bit x_drop, x_heat, x_valve, x_ready, x_out, x_empty;

  task automatic check(input string tag, input logic got, input logic exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("cup_drop", cup_drop, x_drop);
    check("heater_on", heater_on, x_heat);
    check("valve_open", valve_open, x_valve);
    check("coffee_ready", coffee_ready, x_ready);
    check("cup_out", cup_out, x_out);
    check("machine_empty", machine_empty, x_empty);
  endtask

  task automatic model_reset();
    m_brew = 0; m_ready = 0; m_fault = 0; m_prev_prep = 0; m_prev_cup = 0;
    m_e = 0; m_age = 0; m_portions = PORT;
    x_drop = 0; x_heat = 0; x_valve = 0; x_ready = 0; x_out = 0; x_empty = 0;
  endtask

  task automatic model_edge(input bit prep, input bit cup, input bit refill_v);
    bit rise, empty_before;
    rise  = prep && !m_prev_prep;
    x_out = 0;
    if (m_ready) begin
      m_age++;
      if ((m_prev_cup && !cup) || (USE_TO && m_age == TO)) begin
        m_ready = 0;
        x_out   = 1;
      end
    end else if (m_brew) begin
      m_e++;
      if (m_e == C && !cup) begin
        m_fault = 1;
        m_brew  = 0;
      end else if (m_e == C + H + P) begin
        m_brew = 0;
        if (m_portions > 0) m_portions--;
        m_ready = 1;
        m_age   = 0;
      end
    end else begin
      empty_before = (m_portions == 0) || m_fault;
      if (refill_v) begin
        m_portions = PORT;
        m_fault    = 0;
      end
      if (rise && (refill_v || !empty_before)) begin
        m_brew = 1;
        m_e    = 0;
      end
    end
    m_prev_prep = prep;
    m_prev_cup  = cup;
    x_drop  = m_brew && (m_e < C);
    x_heat  = m_brew && (m_e >= C) && (m_e < C + H);
    x_valve = m_brew && (m_e >= C + H);
    x_ready = m_ready;
    x_empty = (m_portions == 0) || m_fault;
  endtask

  task automatic step(input bit p, input bit c, input bit r);
    prepare_coffee = p;
    cup_sensor     = c;
    refill         = r;
    @(posedge clk11m);
    model_edge(p, c, r);
    #1;
    check_outputs();
  endtask

  task automatic run_cycles(input int n, input bit p, input bit c, input bit r);
    for (int i = 0; i < n; i++) step(p, c, r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk11m);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  task automatic brew(input bit remove);
    run_cycles(1, 1, 0, 0);
    run_cycles(2, 0, 1, 0);
    run_cycles(20, 0, 1, 0);
    if (remove) run_cycles(3, 0, 0, 0);
  endtask

  initial begin
    bit p, c, r;
    rst_n = 1'b0;
    prepare_coffee = 0; cup_sensor = 0; refill = 0;
    model_reset();
    #12;
    check_outputs();
    rst_n = 1'b1;
    #4;

    // Single brew, then drain the remaining portions and try an empty machine.
    brew(1);
    brew(1);
    brew(1);
    run_cycles(1, 1, 1, 0);
    run_cycles(25, 0, 1, 0);
    run_cycles(2, 0, 0, 0);
    run_cycles(1, 0, 0, 1);
    brew(1);

    // Cup magazine fault, then service refill.
    run_cycles(1, 1, 0, 0);
    run_cycles(10, 0, 0, 0);
    run_cycles(1, 0, 0, 1);

    // Held request, then a second request arriving during HEAT.
    run_cycles(40, 1, 1, 0);
    run_cycles(2, 0, 0, 0);
    run_cycles(1, 1, 1, 0);
    run_cycles(6, 0, 1, 0);
    run_cycles(1, 1, 1, 0);
    run_cycles(20, 0, 1, 0);
    run_cycles(2, 0, 0, 0);

    // Reset during HEAT, then a fresh brew.
    run_cycles(1, 1, 1, 0);
    run_cycles(7, 0, 1, 0);
    do_reset();
    brew(1);

    // Start and refill in the same IDLE cycle on an empty machine.
    brew(1);
    brew(1);
    run_cycles(1, 1, 1, 1);
    run_cycles(22, 0, 1, 0);
    run_cycles(2, 0, 0, 0);

    p = 0; c = 0; r = 0;
    for (int i = 0; i < 3000; i++) begin
      if (p) p = ($urandom_range(0, 2) != 0);
      else   p = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) == 0) c = !c;
      r = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(p, c, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
